hsv_pwm_driver: RTL and testbench
=================================

# hsv_pwm_driver

Consumer of the 4-bit mode code produced by the button-driven mode selector. Holds the hue, saturation and value registers and updates them according to the active mode. Converts HSV to RGB duty cycles in a 3-stage pipeline. Drives three PWM outputs for the board's RGB LED.

## Interface
- STEP_TICKS, 1000000: clock cycles per hue-step tick (0.1 s at 10 MHz).
- clk  in  1  system clock, 10 MHz nominal.
- reset  in  1  reset, asynchronous and active-low (0 = reset asserted).
- sost  in  4  mode code 0..6; codes 7..15 mean hold.
- h  in  9  hue from switches, degrees.
- s  in  7  saturation from switches, percent.
- v  in  7  value from switches, percent.
- hue_o  out  9  current hue register, 0..359.
- duty_r, duty_g, duty_b  out  7 each  pipelined duty values, 0..100.
- led_r, led_g, led_b  out  1 each  registered PWM outputs.

## Operation
- State registers and their reset values:
  - hue = 0, sat = 100, val = 100.
  - tick counter = 0.
  - PWM counter = 0.
  - All pipeline, duty and latched-duty registers = 0.
  - All LEDs = 0.
- Tick counter:
  - Counts 0..STEP_TICKS-1 and wraps, free-running.
  - tick = 1 for one cycle when count == STEP_TICKS-1.
  - A mode change does not clear the counter.
- Mode actions, evaluated every cycle:
  - 0: hue <= 120.
  - 1: on tick, hue <= (hue+60) mod 360.
  - 2: on tick, hue <= (hue+1) mod 360.
  - 3: hue <= min(h, 359).
  - 4: val <= min(v, 100).
  - 5: sat <= min(s, 100).
  - 6: sat <= 50, val <= 50.
  - 7..15: all registers hold.
  - Registers not named in the active mode hold their values.
- HSV to RGB conversion, all integer floor arithmetic:
  - region = hue/60 (0..5); f = hue − 60·region (0..59).
  - mx = val; mn = val·(100−sat)/100; x = (mx−mn)·f/60.
  - up = mn + x; dn = mx − x.
  - region 0: R=mx, G=up, B=mn.
  - region 1: R=dn, G=mx, B=mn.
  - region 2: R=mn, G=mx, B=up.
  - region 3: R=mn, G=dn, B=mx.
  - region 4: R=up, G=mn, B=mx.
  - region 5: R=mx, G=mn, B=dn.
  - Intermediate products need at least 14 bits. Results always lie in 0..100 and need no clamp.
- Pipeline stages:
  - S1 registers region, f and mn.
  - S2 registers x.
  - S3 registers duty_r/g/b.
- PWM:
  - Counter runs 0..99 and wraps (period 100 cycles).
  - At counter == 0, duty_r/g/b are latched into the active-duty registers, so duty changes take effect only at a period boundary.
  - led_c <= (counter < active_duty_c).
  - Duty 0 gives a constant low output; duty 100 gives a constant high output.

## Timing
- sost, h, s and v are sampled at the clock edge; hue, sat and val update on that same edge (1-cycle latency from input to hue_o).
- duty_* reflects a hue/sat/val change 3 cycles after the register update.
- LED outputs follow the new duty from the first period that starts after duty_* changes. Each output is registered one cycle behind the counter compare.
- Reset assertion clears all registers immediately, independent of clk, including mid-period.
- After reset release, the first PWM period starts with counter = 0 on the first clock edge.
- A hue wrap at 359→0 in mode 2, or 300→0 in mode 1, is a normal step and causes no glitch.
- A tick that coincides with a mode switch applies the action of the new mode.

## Test plan
- Release reset, sost=0, s=v=100.
  - hue_o=120 after 1 cycle.
  - duty = (0,100,0) 4 cycles later.
  - From the next period, led_g stays at 1 and led_r, led_b stay at 0.
- STEP_TICKS=4, sost=0 then sost=1.
  - hue_o goes 120→180→240→300→0→60, one step every 4 cycles.
  - At hue 300: duty = (100,0,100).
- sost=3, h=400.
  - hue_o=359.
  - Then h=30: hue_o=30 and duty = (100,50,0). led_g is high for exactly 50 of 100 cycles.
- sost=0, then sost=6.
  - sat=val=50.
  - duty = (25,50,25). led_r is high for 25 cycles per period.
- sost=5 with s=120, then sost=4 with v=0.
  - sat=100, val=0.
  - All duty values are 0 and all LEDs stay low for the full period.
- STEP_TICKS=4, sost=2, hue at 359, assert reset mid-PWM-period (counter=40).
  - All outputs go to 0 asynchronously.
  - After release: hue_o=0, sat=val=100, and the tick counter restarts from 0.

Source files
------------

// File: rtl/hsv_pwm_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : hsv_pwm_driver_if
// Description : Mode/HSV inputs and duty/PWM outputs of the HSV PWM driver.
// Revision    : 1.0
// ============================================================================
interface hsv_pwm_driver_if;
    logic [3:0] sost;
    logic [8:0] h;
    logic [6:0] s;
    logic [6:0] v;
    logic [8:0] hue_o;
    logic [6:0] duty_r;
    logic [6:0] duty_g;
    logic [6:0] duty_b;
    logic       led_r;
    logic       led_g;
    logic       led_b;

    modport master (
        output sost, h, s, v,
        input  hue_o, duty_r, duty_g, duty_b, led_r, led_g, led_b
    );

    modport slave (
        input  sost, h, s, v,
        output hue_o, duty_r, duty_g, duty_b, led_r, led_g, led_b
    );
endinterface
`default_nettype wire

// File: rtl/hsv_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : hsv_pwm_driver
// Description : Mode-driven HSV registers, 3-stage HSV->RGB pipeline, RGB PWM.
// Revision    : 1.0
// ============================================================================
module hsv_pwm_driver #(
    parameter int unsigned STEP_TICKS = 1000000
) (
    input  wire logic           clk,
    input  wire logic           reset,
    hsv_pwm_driver_if.slave     bus
);
    localparam int unsigned    C_TW        = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [C_TW-1:0] C_TICK_LAST = C_TW'(STEP_TICKS - 1);

    logic [C_TW-1:0] tick_cnt_q;
    logic [8:0]      hue_q, hue_d;
    logic [6:0]      sat_q, sat_d, val_q, val_d;
    logic            w_tick;

    logic [2:0]  s1_region_q, s2_region_q, w_region;
    logic [5:0]  s1_f_q;
    logic [6:0]  s1_mn_q, s1_mx_q, s2_mn_q, s2_mx_q, s2_x_q;
    logic [8:0]  w_base;
    logic [13:0] w_mn_prod, w_x_prod;
    logic [6:0]  w_up, w_dn;

    logic [6:0]  duty_r_q, duty_g_q, duty_b_q, duty_r_d, duty_g_d, duty_b_d;
    logic [6:0]  pwm_cnt_q, act_r_q, act_g_q, act_b_q;
    logic [6:0]  w_act_r, w_act_g, w_act_b;
    logic        led_r_q, led_g_q, led_b_q;

    assign w_tick = (tick_cnt_q == C_TICK_LAST);

    always_comb begin
        hue_d = hue_q;
        sat_d = sat_q;
        val_d = val_q;
        case (bus.sost)
            4'd0: hue_d = 9'd120;
            4'd1: if (w_tick) hue_d = (hue_q >= 9'd300) ? hue_q - 9'd300 : hue_q + 9'd60;
            4'd2: if (w_tick) hue_d = (hue_q >= 9'd359) ? 9'd0 : hue_q + 9'd1;
            4'd3: hue_d = (bus.h > 9'd359) ? 9'd359 : bus.h;
            4'd4: val_d = (bus.v > 7'd100) ? 7'd100 : bus.v;
            4'd5: sat_d = (bus.s > 7'd100) ? 7'd100 : bus.s;
            4'd6: begin
                sat_d = 7'd50;
                val_d = 7'd50;
            end
            default: ;
        endcase
    end

    // Region found by compare chain so f is a plain subtraction, no divider on hue.
    always_comb begin
        w_region = 3'd0;
        w_base   = 9'd0;
        if (hue_q >= 9'd300)      begin w_region = 3'd5; w_base = 9'd300; end
        else if (hue_q >= 9'd240) begin w_region = 3'd4; w_base = 9'd240; end
        else if (hue_q >= 9'd180) begin w_region = 3'd3; w_base = 9'd180; end
        else if (hue_q >= 9'd120) begin w_region = 3'd2; w_base = 9'd120; end
        else if (hue_q >= 9'd60)  begin w_region = 3'd1; w_base = 9'd60;  end
    end

    assign w_mn_prod = 14'(val_q) * (14'd100 - 14'(sat_q));
    assign w_x_prod  = 14'(s1_mx_q - s1_mn_q) * 14'(s1_f_q);
    assign w_up      = s2_mn_q + s2_x_q;
    assign w_dn      = s2_mx_q - s2_x_q;

    always_comb begin
        duty_r_d = s2_mn_q;
        duty_g_d = s2_mn_q;
        duty_b_d = s2_mn_q;
        case (s2_region_q)
            3'd0:    begin duty_r_d = s2_mx_q; duty_g_d = w_up;    duty_b_d = s2_mn_q; end
            3'd1:    begin duty_r_d = w_dn;    duty_g_d = s2_mx_q; duty_b_d = s2_mn_q; end
            3'd2:    begin duty_r_d = s2_mn_q; duty_g_d = s2_mx_q; duty_b_d = w_up;    end
            3'd3:    begin duty_r_d = s2_mn_q; duty_g_d = w_dn;    duty_b_d = s2_mx_q; end
            3'd4:    begin duty_r_d = w_up;    duty_g_d = s2_mn_q; duty_b_d = s2_mx_q; end
            default: begin duty_r_d = s2_mx_q; duty_g_d = s2_mn_q; duty_b_d = w_dn;    end
        endcase
    end

    // New duty is used from the counter==0 compare onward, so every period is clean.
    assign w_act_r = (pwm_cnt_q == 7'd0) ? duty_r_q : act_r_q;
    assign w_act_g = (pwm_cnt_q == 7'd0) ? duty_g_q : act_g_q;
    assign w_act_b = (pwm_cnt_q == 7'd0) ? duty_b_q : act_b_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q  <= '0;
            hue_q       <= 9'd0;
            sat_q       <= 7'd100;
            val_q       <= 7'd100;
            s1_region_q <= '0;
            s1_f_q      <= '0;
            s1_mn_q     <= '0;
            s1_mx_q     <= '0;
            s2_region_q <= '0;
            s2_x_q      <= '0;
            s2_mn_q     <= '0;
            s2_mx_q     <= '0;
            duty_r_q    <= '0;
            duty_g_q    <= '0;
            duty_b_q    <= '0;
            pwm_cnt_q   <= '0;
            act_r_q     <= '0;
            act_g_q     <= '0;
            act_b_q     <= '0;
            led_r_q     <= 1'b0;
            led_g_q     <= 1'b0;
            led_b_q     <= 1'b0;
        end else begin
            tick_cnt_q  <= w_tick ? '0 : tick_cnt_q + 1'b1;
            hue_q       <= hue_d;
            sat_q       <= sat_d;
            val_q       <= val_d;
            s1_region_q <= w_region;
            s1_f_q      <= 6'(hue_q - w_base);
            s1_mn_q     <= 7'(w_mn_prod / 14'd100);
            s1_mx_q     <= val_q;
            s2_region_q <= s1_region_q;
            s2_x_q      <= 7'(w_x_prod / 14'd60);
            s2_mn_q     <= s1_mn_q;
            s2_mx_q     <= s1_mx_q;
            duty_r_q    <= duty_r_d;
            duty_g_q    <= duty_g_d;
            duty_b_q    <= duty_b_d;
            pwm_cnt_q   <= (pwm_cnt_q == 7'd99) ? 7'd0 : pwm_cnt_q + 7'd1;
            act_r_q     <= w_act_r;
            act_g_q     <= w_act_g;
            act_b_q     <= w_act_b;
            led_r_q     <= (pwm_cnt_q < w_act_r);
            led_g_q     <= (pwm_cnt_q < w_act_g);
            led_b_q     <= (pwm_cnt_q < w_act_b);
        end
    end

    assign bus.hue_o  = hue_q;
    assign bus.duty_r = duty_r_q;
    assign bus.duty_g = duty_g_q;
    assign bus.duty_b = duty_b_q;
    assign bus.led_r  = led_r_q;
    assign bus.led_g  = led_g_q;
    assign bus.led_b  = led_b_q;
endmodule
`default_nettype wire

// File: tb/tb_hsv_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_hsv_pwm_driver
// Description : Randomized + directed bench for hsv_pwm_driver with a
//               cycle-indexed HSV/PWM reference model.
// Revision    : 1.0
// ============================================================================
module tb_hsv_pwm_driver;
    localparam int T = 4;
    localparam int N = 8192;

    logic clk;
    logic rst_n;
    hsv_pwm_driver_if bus ();

    hsv_pwm_driver #(.STEP_TICKS(T)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model history indexed by edges since reset release (index 0 = reset state)
    int mh [N];
    int ms [N];
    int mv [N];
    int er [N];
    int eg [N];
    int eb [N];
    int k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t k=%0d)", tag, obs, exp, $time, k);
        end
    endtask

    function automatic logic [20:0] hsv2rgb(input int hue, input int sat, input int val);
        int region, f, mx, mn, x, up, dn, r, g, b;
        region = hue / 60;
        f  = hue % 60;
        mx = val;
        mn = val * (100 - sat) / 100;
        x  = (mx - mn) * f / 60;
        up = mn + x;
        dn = mx - x;
        case (region)
            0: begin r = mx; g = up; b = mn; end
            1: begin r = dn; g = mx; b = mn; end
            2: begin r = mn; g = mx; b = up; end
            3: begin r = mn; g = dn; b = mx; end
            4: begin r = up; g = mn; b = mx; end
            default: begin r = mx; g = mn; b = dn; end
        endcase
        return {r[6:0], g[6:0], b[6:0]};
    endfunction

    task automatic model_reset();
        k = 0;
        mh[0] = 0; ms[0] = 100; mv[0] = 100;
        er[0] = 0; eg[0] = 0; eb[0] = 0;
    endtask

    task automatic model_edge();
        int hh, ss, vv;
        bit tick;
        logic [20:0] rgb;
        k++;
        if (k >= N) $fatal(1, "FAIL model_depth: got %0d expected below %0d", k, N);
        tick = (((k - 1) % T) == T - 1);
        hh = mh[k-1]; ss = ms[k-1]; vv = mv[k-1];
        case (int'(bus.sost))
            0: hh = 120;
            1: if (tick) hh = (hh + 60) % 360;
            2: if (tick) hh = (hh + 1) % 360;
            3: hh = (int'(bus.h) < 359) ? int'(bus.h) : 359;
            4: vv = (int'(bus.v) < 100) ? int'(bus.v) : 100;
            5: ss = (int'(bus.s) < 100) ? int'(bus.s) : 100;
            6: begin ss = 50; vv = 50; end
            default: ;
        endcase
        mh[k] = hh; ms[k] = ss; mv[k] = vv;
        if (k < 3) rgb = '0;
        else       rgb = hsv2rgb(mh[k-3], ms[k-3], mv[k-3]);
        er[k] = int'(rgb[20:14]);
        eg[k] = int'(rgb[13:7]);
        eb[k] = int'(rgb[6:0]);
    endtask

    task automatic check_now();
        int p, d;
        chk("hue", 32'(bus.hue_o), 32'(mh[k]));
        chk("duty_r", 32'(bus.duty_r), 32'(er[k]));
        chk("duty_g", 32'(bus.duty_g), 32'(eg[k]));
        chk("duty_b", 32'(bus.duty_b), 32'(eb[k]));
        if (k == 0) begin
            chk("led_r", 32'(bus.led_r), 32'd0);
            chk("led_g", 32'(bus.led_g), 32'd0);
            chk("led_b", 32'(bus.led_b), 32'd0);
        end else begin
            // Each period uses the duty visible just before its first edge
            p = (k - 1) % 100;
            d = k - 1 - p;
            chk("led_r", 32'(p < er[d]), 32'(bus.led_r));
            chk("led_g", 32'(p < eg[d]), 32'(bus.led_g));
            chk("led_b", 32'(p < eb[d]), 32'(bus.led_b));
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_now();
        end
    endtask

    task automatic set_in(input int so, input int hh, input int ss, input int vv);
        bus.sost = 4'(so);
        bus.h    = 9'(hh);
        bus.s    = 7'(ss);
        bus.v    = 7'(vv);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 100, 100);
        model_reset();
        repeat (3) @(negedge clk);
        check_now();
        rst_n = 1'b1;

        // Fixed green, then hue stepping by 60 on ticks
        cyc(250);
        set_in(1, 0, 100, 100);
        cyc(60);

        // Clamped switch hue, then hue 30 for a 50% green
        set_in(3, 400, 100, 100);
        cyc(5);
        set_in(3, 30, 100, 100);
        cyc(250);

        // Half saturation / half value on green
        set_in(0, 0, 100, 100);
        cyc(5);
        set_in(6, 0, 100, 100);
        cyc(250);

        // Saturation clamp, then zero value
        set_in(5, 0, 120, 100);
        cyc(5);
        set_in(4, 0, 120, 0);
        cyc(250);

        // Randomized mode and switch traffic
        for (int seg = 0; seg < 40; seg++) begin
            set_in(int'($urandom_range(0, 15)), int'($urandom_range(0, 511)),
                   int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
            cyc(int'($urandom_range(1, 40)));
        end

        // Hue at 359 stepping by 1, reset mid-period at counter 40
        set_in(3, 359, 100, 100);
        cyc(2);
        set_in(2, 359, 100, 100);
        for (int i = 0; i < 100 && (k % 100) != 40; i++) cyc(1);
        chk("pwm_at_40", 32'(k % 100), 32'd40);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_now();
        @(posedge clk);
        @(negedge clk);
        check_now();
        rst_n = 1'b1;
        cyc(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
